// File: rtl/msg_out_serializer.sv
// Record buffer plus beat serializer. Each buffered record leaves as one status
// word followed by its data MSB-first, and a saturating lost-packet count is kept.
module msg_out_serializer #(
    parameter int REC_W = 296,
    parameter int OUT_W = 32,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             reset_b,
    input  logic [0:REC_W-1] recIn,
    input  logic             recIn_val,
    output logic             recIn_ready,
    input  logic             recIn_lost,
    output logic [OUT_W-1:0] dataOut,
    output logic             dataOut_val,
    input  logic             dataOut_ready,
    output logic             dataOut_last,
    output logic [15:0]      lostCount
);

    localparam int NB    = (REC_W + OUT_W - 1) / OUT_W + 1;
    localparam int PAD_W = (NB - 1) * OUT_W;
    localparam int PW    = $clog2(DEPTH);
    localparam int CW    = $clog2(DEPTH + 1);
    localparam int BW    = $clog2(NB);
    localparam int IW    = $clog2(PAD_W);

    logic [0:REC_W-1] r_mem [DEPTH];
    logic [DEPTH-1:0] r_lost;
    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic [BW-1:0]    r_beat;
    logic [15:0]      r_rec_cnt;
    logic [15:0]      r_lost_cnt;

    logic             w_push;
    logic             w_pop;
    logic             w_val;
    logic             w_last_beat;
    logic [0:PAD_W-1] w_padded;
    logic [IW-1:0]    w_base;
    logic [OUT_W-1:0] w_data;

    assign w_val       = (r_count != CW'(0));
    assign recIn_ready = (r_count != CW'(DEPTH));
    assign w_push      = recIn_val && recIn_ready;
    assign w_last_beat = (r_beat == BW'(NB - 1));
    assign w_pop       = w_val && dataOut_ready && w_last_beat;

    // Record payload storage; contents are only observed behind a nonzero count
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= recIn;
        end
    end

    // Buffer pointers, occupancy and per-entry lost flags
    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_lost   <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr         <= r_wr_ptr + PW'(1);
                r_lost[r_wr_ptr] <= recIn_lost;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Beat index within the head record and completed-record counter
    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            r_beat    <= '0;
            r_rec_cnt <= 16'd0;
        end else if (w_val && dataOut_ready) begin
            if (w_last_beat) begin
                r_beat    <= '0;
                r_rec_cnt <= r_rec_cnt + 16'd1;
            end else begin
                r_beat <= r_beat + BW'(1);
            end
        end
    end

    // Saturating count of accepted records flagged as lost
    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            r_lost_cnt <= 16'd0;
        end else if (w_push && recIn_lost && (r_lost_cnt != 16'hFFFF)) begin
            r_lost_cnt <= r_lost_cnt + 16'd1;
        end
    end

    // Beat mux: status word at beat 0, then zero-padded record slices
    always_comb begin
        w_padded            = '0;
        w_padded[0:REC_W-1] = r_mem[r_rd_ptr];
        w_base              = '0;
        w_data              = '0;
        if (!w_val) begin
            w_data = '0;
        end else if (r_beat == BW'(0)) begin
            w_data[OUT_W-1] = r_lost[r_rd_ptr];
            w_data[15:0]    = r_rec_cnt;
        end else begin
            w_base = IW'((int'(r_beat) - 1) * OUT_W);
            w_data = w_padded[w_base +: OUT_W];
        end
    end

    assign dataOut      = w_data;
    assign dataOut_val  = w_val;
    assign dataOut_last = w_val && w_last_beat;
    assign lostCount    = r_lost_cnt;

endmodule
